// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a 3-sample majority vote at mid-bit.
// Presents each good byte with a one-cycle VALID strobe; a low stop bit gives FRAME_ERR instead.
module uart_rx #(
  parameter int CLKS_PER_TICK = 27,
  parameter int TICK_W        = 5
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e            state_q;
  logic              rx_meta_q;
  logic              rx_s_q;
  logic              rx_prev_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [3:0]        s_q;
  logic [2:0]        bit_idx_q;
  logic [1:0]        samp_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              busy_q;

  logic tick;
  logic decide;
  logic fall;
  logic vote_d;

  assign tick   = (state_q != S_IDLE) && (tick_cnt_q == TICK_W'(CLKS_PER_TICK - 1));
  assign decide = tick && (s_q == 4'd9);
  assign fall   = rx_prev_q && !rx_s_q;
  // The s==9 sample is the live rx_s; the s==7 and s==8 samples were captured earlier.
  assign vote_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  // NOTE: every register here is written with <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see this cycle's new values.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      // Synchroniser preset high so a released reset on an idle line is not a start edge.
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      s_q        <= '0;
      bit_idx_q  <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;

      if (state_q == S_IDLE) begin
        tick_cnt_q <= '0;
        s_q        <= '0;
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
        if (tick) begin
          s_q <= s_q + 4'd1;
          if (s_q == 4'd7) samp_q[0] <= rx_s_q;
          if (s_q == 4'd8) samp_q[1] <= rx_s_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q   <= S_START;
            bit_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_START: begin
          if (decide) begin
            if (!vote_d) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (decide) begin
            shift_q   <= {vote_d, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (vote_d) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // A line held low must go high before any new start edge can be seen.
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a negedge monitor pops
// and compares them whenever VALID or FRAME_ERR fires.
module tb_uart_rx;

  localparam int BIT = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         chk_lat;
    int         start;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;

  uart_rx dut (
    .CLK_50M  (clk),
    .RST_N    (rst_n),
    .RX       (rx),
    .DATA     (data),
    .VALID    (valid),
    .FRAME_ERR(ferr),
    .BUSY     (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input bit lat);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = d;
    e.chk_lat = lat;
    e.start   = cyc;
    sb_q.push_back(e);
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.is_err  = 1'b1;
    e.data    = 8'h00;
    e.chk_lat = 1'b0;
    e.start   = cyc;
    sb_q.push_back(e);
  endtask

  // Start bit, 8 data bits LSB first, stop bit; each held for BIT cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      wait_cycles(BIT);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ferr) check("strobe_exclusive", 32'd1, 32'd0);
      if (valid || ferr) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, valid, ferr}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("strobe_kind_ferr", {31'd0, ferr}, {31'd0, mon_e.is_err});
          if (!mon_e.is_err) begin
            check("valid_data", {24'd0, data}, {24'd0, mon_e.data});
            last_good = mon_e.data;
          end else begin
            check("ferr_data_hold", {24'd0, data}, {24'd0, last_good});
          end
          if (mon_e.chk_lat) check_range("valid_latency", cyc - mon_e.start, 4131, 4191);
        end
      end
    end
  end

  initial begin
    int bad;

    // Reset and a long idle line.
    wait_cycles(5);
    @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (data !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_quiet_cycles_bad", bad, 0);
    wait_cycles(1);

    // 0x55 with latency and BUSY checks.
    expect_byte(8'h55, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        wait_cycles(10);
        check("busy_after_start", {31'd0, busy}, 32'd1);
      end
    join
    check("frame55_drained", sb_q.size(), 0);
    check("busy_after_55", {31'd0, busy}, 32'd0);
    check("data_55_held", {24'd0, data}, 32'h55);

    // Short low glitch: rejected at the start decision.
    wait_cycles(200);
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(200);
    check("glitch_busy_fell", {31'd0, busy}, 32'd0);
    wait_cycles(500);
    check("glitch_data_held", {24'd0, data}, 32'h55);

    // Framing error on 0xA3: line stays low through stop, then released.
    expect_ferr();
    send_frame(8'hA3, 1'b0);
    check("ferr_drained", sb_q.size(), 0);
    check("busy_in_break", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_cycles(6);
    check("busy_after_break", {31'd0, busy}, 32'd0);
    check("data_after_ferr", {24'd0, data}, 32'h55);
    wait_cycles(300);

    // Back-to-back 0x00, 0xFF with a 27-cycle glitch centred on data bit 2 of 0x00.
    expect_byte(8'h00, 1'b0);
    expect_byte(8'hFF, 1'b0);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        wait_cycles(BIT * 3 + BIT / 2 - 13);
        rx = ~rx;
        wait_cycles(27);
        rx = ~rx;
      end
    join
    wait_cycles(100);
    check("b2b_drained", sb_q.size(), 0);
    check("data_ff_held", {24'd0, data}, 32'hFF);

    // Reset during data bit 4, then 0x0F.
    rx = 1'b0;
    wait_cycles(BIT * 5 + 100);
    rst_n = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_ferr", {31'd0, ferr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    wait_cycles(4);
    rx = 1'b1;
    rst_n = 1'b1;
    wait_cycles(1000);
    check("aborted_no_strobe", sb_q.size(), 0);
    expect_byte(8'h0F, 1'b0);
    send_frame(8'h0F, 1'b1);
    wait_cycles(100);
    check("final_drained", sb_q.size(), 0);
    check("data_0f_held", {24'd0, data}, 32'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1 serial frames. Clocked by the board CLK_50M, alongside the clock divider. It runs its own 16x-oversampling tick counter rather than using a derived clock. It deserialises the RX pin into bytes and presents each byte with a one-cycle VALID strobe to the downstream logic (display/echo path).

Parameters:
- CLKS_PER_TICK, default 27: CLK_50M cycles per oversample tick. 50M / (115200 × 16) ≈ 27.
- TICK_W, default 5: width of the tick counter. Must satisfy 2^TICK_W > CLKS_PER_TICK - 1.

Ports:
- CLK_50M, input, 1: system clock, 50 MHz. All logic is on posedge.
- RST_N, input, 1: asynchronous active-low reset.
- RX, input, 1: asynchronous serial line, idle high.
- DATA, output, 8: last correctly received byte. Held until the next good frame.
- VALID, output, 1: one-cycle strobe when DATA updates.
- FRAME_ERR, output, 1: one-cycle strobe when the stop bit is sampled low.
- BUSY, output, 1: high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (asynchronous, RST_N=0):
  - DATA=8'h00, VALID=0, FRAME_ERR=0, BUSY=0.
  - State=IDLE, all counters 0.
  - Synchroniser flops preset to 1.
- Synchronisation: RX passes through 2 flops giving rx_s. All decisions use rx_s only.
- Tick generator:
  - tick_cnt counts 0..CLKS_PER_TICK-1.
  - tick=1 for one cycle when tick_cnt==CLKS_PER_TICK-1, then tick_cnt wraps to 0.
  - Held at 0 in IDLE.
- Sample counter s (4 bits): increments on each tick and wraps 15->0. Cleared when leaving IDLE.
- Majority vote:
  - rx_s is captured on the ticks where s==7, 8 and 9.
  - Bit value = majority (≥2 of 3). It is evaluated on the tick where s==9.
- States:
  - IDLE: on a falling edge of rx_s (previous 1, current 0), go to START and clear tick_cnt, s and bit_idx.
  - START: at the s==9 decision, if the vote is 0 go to DATA; if it is 1 (glitch) go to IDLE with no strobes.
  - DATA: at each s==9 decision, shift the vote into the shift register LSB-first and increment bit_idx. After bit_idx reaches 7 and that bit is stored, go to STOP.
  - STOP, at the s==9 decision:
    - Vote 1: DATA<=shift register; VALID=1 for the next cycle; go to IDLE.
    - Vote 0: FRAME_ERR=1 for the next cycle; DATA unchanged; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A line held low never produces a frame.
- Latency: the VALID rising edge follows the falling edge on RX by 2 sync cycles + 154 ticks (9×16+10) + 1 cycle. That is about 4161 cycles at the default parameter.
- Back-to-back frames: returning to IDLE at mid-stop-bit means a start edge arriving immediately after the stop bit is caught. Zero idle gap is supported.
- Strobe exclusivity: VALID and FRAME_ERR are never high together. Each is high for exactly one cycle per frame.
- Reset mid-frame: everything is cleared immediately and the partial byte is discarded. The first falling edge after release starts a new frame.
- A falling edge seen in any state other than IDLE is ignored.

Test Plan:
- Reset, then RX idle high for 10000 cycles -> DATA=0x00, VALID=0, FRAME_ERR=0, BUSY=0 throughout.
- Send 0x55 at 115200 baud (434 cycles/bit) -> after 4161±30 cycles from the start edge, VALID=1 for exactly 1 cycle and DATA=0x55. BUSY high from ~3 cycles after the start edge until VALID.
- Pull RX low for 100 cycles, then high -> at the start decision, return to IDLE. No VALID, no FRAME_ERR, BUSY falls within 300 cycles.
- Send 0xA3 with the stop bit forced 0, then release the line high -> one FRAME_ERR pulse, DATA stays at the previous 0x55, no VALID. BUSY falls when RX returns high.
- Send 0x00 then 0xFF with zero idle gap, and invert RX for 27 cycles centred on bit 2 of 0x00 -> two VALIDs with DATA=0x00 then 0xFF (the majority vote rejects the glitch).
- Assert RST_N low for 5 cycles during bit 4 of a frame, then send 0x0F -> outputs are 0 during reset. The aborted frame yields no strobe, and 0x0F is received with VALID once.
